ov7670_stream_gen: RTL and testbench

OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

---
 rtl/dicerace_cam_pkg.sv | 44 ++++
 rtl/cam_pattern_gen.sv | 32 +++
 rtl/ov7670_stream_gen.sv | 206 ++++++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dicerace_cam_pkg.sv
// rtl/dicerace_cam_pkg.sv - shared state/pattern types and RGB565 bar colours for the camera emulator
package dicerace_cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFP    = 3'd5
    } cam_state_e;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_SOLID    = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_CHECKER  = 2'd3
    } pattern_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    localparam int BAR_PIXELS = 20;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// rtl/cam_pattern_gen.sv - combinational (x, y, pattern, solid) to RGB565 pixel mapping
module cam_pattern_gen
    import dicerace_cam_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  pattern_e      sel_i,
    input  logic [15:0]   solid_i,
    output logic [15:0]   rgb_o
);

    logic [15:0] x_ext;
    logic [15:0] y_ext;
    logic [15:0] bar;

    always_comb begin
        x_ext = 16'(x_i);
        y_ext = 16'(y_i);
        bar   = x_ext / 16'(BAR_PIXELS);
        case (sel_i)
            PAT_BARS:     rgb_o = bar_colour((bar > 16'd7) ? 3'd7 : bar[2:0]);
            PAT_SOLID:    rgb_o = solid_i;
            // {x[7:3], y[6:1], 5'b0} built with masks so every coordinate bit is consumed
            PAT_GRADIENT: rgb_o = ((x_ext & 16'h00F8) << 8) | ((y_ext & 16'h007E) << 4);
            default:      rgb_o = (((x_ext ^ y_ext) & 16'h0008) != 16'h0000) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670-style RGB565 byte-stream emulator with vsync/href framing
module ov7670_stream_gen
    import dicerace_cam_pkg::*;
#(
    parameter int IMG_WIDTH    = 160,
    parameter int IMG_HEIGHT   = 120,
    parameter int VSYNC_LINES  = 3,
    parameter int VBP_LINES    = 2,
    parameter int VFP_LINES    = 2,
    parameter int HBLANK_SLOTS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb565,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        busy
);

    localparam int LINE_SLOTS  = 2 * IMG_WIDTH + HBLANK_SLOTS;
    localparam int FRAME_LINES = VSYNC_LINES + VBP_LINES + IMG_HEIGHT + VFP_LINES;
    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int SW = $clog2(LINE_SLOTS);
    localparam int LW = $clog2(FRAME_LINES);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(LINE_SLOTS - 1);
    localparam logic [SW-1:0] HB_LAST = SW'(HBLANK_SLOTS - 1);

    cam_state_e      state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [LW-1:0]   line_q, line_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            lo_q, lo_d;
    pattern_e        sel_q, sel_d;
    logic [15:0]     solid_q, solid_d;
    logic [7:0]      count_q, count_d;
    logic            done_q, done_d;
    logic            pclk_q;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      data_q, data_d;
    logic            busy_q, busy_d;
    logic            slot_last;
    logic            phase_last;
    logic [15:0]     pix;

    assign slot_last = (slot_q == S_LAST);

    always_comb begin
        case (state_q)
            ST_VSYNC: phase_last = (line_q == LW'(VSYNC_LINES - 1));
            ST_VBP:   phase_last = (line_q == LW'(VBP_LINES - 1));
            ST_VFP:   phase_last = (line_q == LW'(VFP_LINES - 1));
            default:  phase_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        line_d  = line_q;
        x_d     = x_q;
        y_d     = y_q;
        lo_d    = lo_q;
        sel_d   = sel_q;
        solid_d = solid_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_VSYNC;
            end
            ST_VSYNC, ST_VBP, ST_VFP: begin
                slot_d = slot_last ? '0 : slot_q + 1'b1;
                if (slot_last) line_d = phase_last ? '0 : line_q + 1'b1;
                if (slot_last && phase_last) begin
                    case (state_q)
                        ST_VSYNC: state_d = ST_VBP;
                        ST_VBP: begin
                            state_d = ST_ACTIVE;
                            x_d     = '0;
                            y_d     = '0;
                            lo_d    = 1'b0;
                        end
                        default: begin
                            done_d  = 1'b1;
                            count_d = count_q + 8'd1;
                            state_d = enable ? ST_VSYNC : ST_IDLE;
                        end
                    endcase
                end
            end
            ST_ACTIVE: begin
                lo_d = ~lo_q;
                if (lo_q) begin
                    if (x_q == X_LAST) begin
                        state_d = ST_HBLANK;
                        slot_d  = '0;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_HBLANK: begin
                slot_d = slot_q + 1'b1;
                if (slot_q == HB_LAST) begin
                    slot_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_VFP;
                        line_d  = '0;
                    end else begin
                        state_d = ST_ACTIVE;
                        x_d     = '0;
                        y_d     = y_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Pattern controls are sampled once per frame, at VSYNC entry
        if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
            sel_d   = pattern_e'(pattern_sel);
            solid_d = solid_rgb565;
            slot_d  = '0;
            line_d  = '0;
        end
    end

    cam_pattern_gen #(
        .XW(XW),
        .YW(YW)
    ) u_pattern (
        .x_i     (x_d),
        .y_i     (y_d),
        .sel_i   (sel_q),
        .solid_i (solid_q),
        .rgb_o   (pix)
    );

    always_comb begin
        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_ACTIVE);
        busy_d  = (state_d != ST_IDLE);
        data_d  = 8'h00;
        if (href_d) data_d = lo_d ? pix[7:0] : pix[15:8];
    end

    // Everything except pclk advances only on the clk edge where pclk falls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            line_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            lo_q    <= 1'b0;
            sel_q   <= PAT_BARS;
            solid_q <= 16'h0000;
            count_q <= 8'h00;
            done_q  <= 1'b0;
            pclk_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            pclk_q <= ~pclk_q;
            done_q <= 1'b0;
            if (pclk_q) begin
                state_q <= state_d;
                slot_q  <= slot_d;
                line_q  <= line_d;
                x_q     <= x_d;
                y_q     <= y_d;
                lo_q    <= lo_d;
                sel_q   <= sel_d;
                solid_q <= solid_d;
                count_q <= count_d;
                done_q  <= done_d;
                vsync_q <= vsync_d;
                href_q  <= href_d;
                data_q  <= data_d;
                busy_q  <= busy_d;
            end
        end
    end

    assign cam_pclk    = pclk_q;
    assign cam_vsync   = vsync_q;
    assign cam_href    = href_q;
    assign cam_data    = data_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb/tb_ov7670_stream_gen.sv - scoreboard bench for ov7670_stream_gen
module tb_ov7670_stream_gen;

    localparam int W   = 48;
    localparam int H   = 16;
    localparam int VS  = 3;
    localparam int VBP = 2;
    localparam int VFP = 2;
    localparam int HB  = 8;
    localparam int LS  = 2 * W + HB;
    localparam int FRAME_SLOTS = (VS + VBP + H + VFP) * LS;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        enable2;
    logic [1:0]  pattern_sel;
    logic [15:0] solid;

    logic        cam_pclk, cam_vsync, cam_href, frame_done, busy;
    logic [7:0]  cam_data, frame_count;
    logic        cam_pclk2, cam_vsync2, cam_href2, frame_done2, busy2;
    logic [7:0]  cam_data2, frame_count2;

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .VSYNC_LINES(VS),
        .VBP_LINES(VBP), .VFP_LINES(VFP), .HBLANK_SLOTS(HB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb565(solid), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .frame_done(frame_done),
        .frame_count(frame_count), .busy(busy)
    );

    ov7670_stream_gen #(
        .IMG_WIDTH(2), .IMG_HEIGHT(2), .VSYNC_LINES(1),
        .VBP_LINES(1), .VFP_LINES(1), .HBLANK_SLOTS(1)
    ) dut_tiny (
        .clk(clk), .reset(reset), .enable(enable2), .pattern_sel(pattern_sel),
        .solid_rgb565(solid), .cam_pclk(cam_pclk2), .cam_vsync(cam_vsync2),
        .cam_href(cam_href2), .cam_data(cam_data2), .frame_done(frame_done2),
        .frame_count(frame_count2), .busy(busy2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int x, input int y,
                                              input logic [1:0] sel, input logic [15:0] sol);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = x[7:0];
        yb = y[7:0];
        case (sel)
            2'd0: begin
                case (x / 20)
                    0:       return 16'hFFFF;
                    1:       return 16'hFFE0;
                    2:       return 16'h07FF;
                    3:       return 16'h07E0;
                    4:       return 16'hF81F;
                    5:       return 16'hF800;
                    6:       return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1:    return sol;
            2'd2:    return {xb[7:3], yb[6:1], 5'b00000};
            default: return (xb[3] ^ yb[3]) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    logic [7:0] sb[$];

    task automatic push_frame(input logic [1:0] sel, input logic [15:0] sol);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                logic [15:0] p;
                p = model_pix(x, y, sel, sol);
                sb.push_back(p[15:8]);
                sb.push_back(p[7:0]);
            end
        end
    endtask

    int   cyc = 0, vs_slots = 0, href_rises = 0, line_bytes = 0;
    int   fd_cnt = 0, fd_cyc = 0, vs_rise_cyc = 0;
    bit   vs_rise_seen = 0, prev_vs = 0, prev_href = 0, have_lo = 0;
    logic [9:0] lo_snap;

    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        if (cam_vsync && !prev_vs) begin
            vs_rise_seen = 1;
            vs_rise_cyc  = cyc;
        end
        prev_vs = cam_vsync;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (!cam_pclk) begin
            lo_snap = {cam_vsync, cam_href, cam_data};
            have_lo = 1;
        end else begin
            if (have_lo) chk("mid_slot_stable", {cam_vsync, cam_href, cam_data}, lo_snap);
            have_lo = 0;
            if (cam_vsync) vs_slots++;
            if (cam_href) begin
                if (!prev_href) begin
                    href_rises++;
                    line_bytes = 0;
                end
                line_bytes++;
                e = 8'hxx;
                if (sb.size() != 0) e = sb.pop_front();
                chk("pixel_byte", cam_data, e);
            end else begin
                if (prev_href) chk("bytes_per_href", line_bytes, 2 * W);
                chk("blank_data_zero", cam_data, 0);
            end
            prev_href = cam_href;
        end
    endtask

    task automatic run_frames(input logic [1:0] sa, input logic [15:0] ca,
                              input logic [1:0] sbs, input logic [15:0] cb, input int n);
        int base;
        int rise0;
        push_frame(sa, ca);
        if (n == 2) push_frame(sbs, cb);
        pattern_sel  = sa;
        solid        = ca;
        vs_slots     = 0;
        href_rises   = 0;
        vs_rise_seen = 0;
        base         = fd_cnt;
        enable       = 1'b1;
        for (int i = 0; i < 6 && !vs_rise_seen; i++) step();
        chk("vsync_start", vs_rise_seen, 1);
        rise0 = vs_rise_cyc;
        for (int i = 0; i < (VS + VBP + H / 2) * LS * 2; i++) step();
        pattern_sel = sbs;
        solid       = cb;
        if (n == 1) enable = 1'b0;
        chk("busy_mid_frame", busy, 1);
        for (int i = 0; i < 2 * FRAME_SLOTS && fd_cnt < base + 1; i++) step();
        chk("frame_done_seen", fd_cnt, base + 1);
        chk("frame_clks", fd_cyc - rise0, 2 * FRAME_SLOTS);
        if (n == 2) begin
            enable = 1'b0;
            for (int i = 0; i < 2 * FRAME_SLOTS + 4 && fd_cnt < base + 2; i++) step();
            chk("second_frame_done", fd_cnt, base + 2);
        end
        chk("busy_at_frame_end", busy, 0);
        for (int i = 0; i < 4 * LS; i++) step();
        chk("no_extra_frame", fd_cnt, base + n);
        chk("idle_vsync_busy", {cam_vsync, busy}, 0);
        chk("href_lines", href_rises, H * n);
        chk("vsync_slots", vs_slots, VS * LS * n);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        bit p0;
        reset       = 1'b1;
        enable      = 1'b0;
        enable2     = 1'b0;
        pattern_sel = 2'd0;
        solid       = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_pclk", cam_pclk, 0);
        chk("rst_vsync", cam_vsync, 0);
        chk("rst_href", cam_href, 0);
        chk("rst_data", cam_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tiny_busy", busy2, 0);
        reset = 1'b0;

        step();
        p0 = cam_pclk;
        step();
        chk("pclk_toggle", cam_pclk, p0 ? 0 : 1);
        for (int i = 0; i < 1000; i++) step();
        chk("idle_no_frame_done", fd_cnt, 0);
        chk("idle_busy", busy, 0);
        chk("idle_no_vsync", vs_rise_seen, 0);
        chk("idle_no_href", href_rises, 0);

        run_frames(2'd0, 16'h0000, 2'd1, 16'h1234, 1);
        chk("count_after_bars", frame_count, 1);

        run_frames(2'd1, 16'hF800, 2'd1, 16'h001F, 2);
        chk("count_after_solid", frame_count, 3);

        run_frames(2'd2, 16'h0000, 2'd3, 16'h0000, 2);
        chk("count_after_grad_chk", frame_count, 5);

        push_frame(2'd3, 16'h0000);
        pattern_sel = 2'd3;
        href_rises  = 0;
        enable      = 1'b1;
        for (int i = 0; i < 2 * FRAME_SLOTS && href_rises == 0; i++) step();
        for (int i = 0; i < 10; i++) step();
        chk("href_before_reset", cam_href, 1);
        chk("count_before_reset", frame_count, 5);
        #1 reset = 1'b1;
        #1;
        chk("abort_href", cam_href, 0);
        chk("abort_count", frame_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_vsync_data", {cam_vsync, cam_data}, 0);
        sb.delete();
        prev_href = 0;
        prev_vs   = 0;
        have_lo   = 0;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        run_frames(2'd0, 16'h0000, 2'd2, 16'h0000, 1);
        chk("count_after_reset_frame", frame_count, 1);

        enable2 = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            for (int i = 0; i < 200 && !frame_done2; i++) @(negedge clk);
            chk("tiny_frame_done", frame_done2, 1);
            chk("tiny_frame_count", frame_count2, k % 256);
            @(negedge clk);
        end
        enable2 = 1'b0;
        repeat (120) @(negedge clk);
        chk("tiny_idle_busy", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
